// File: rtl/ir_packet_scheduler.sv
// Bus-mapped packet scheduler for the IR transmitter: stages the direction command, issues
// periodic and one-shot SEND_PACKET pulses, and enforces a hold-off between packets.
module ir_packet_scheduler #(
  parameter logic [7:0]  BASE_ADDR = 8'h90,
  parameter int unsigned PERIOD    = 10_000_000,
  parameter int unsigned HOLDOFF   = 1_700_000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_DATA_IN,
  input  logic       BUS_WE,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OUT_EN,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFire = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(PERIOD - 1);
  // Leaving hold-off at this count lets a pending packet fire exactly HOLDOFF after the last.
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLDOFF - 2);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cmd_stage_q;
  logic [3:0]       command_q;
  logic             enable_q;
  logic             pending_q;
  logic [7:0]       pkt_cnt_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [7:0]       data_out_q;
  logic             data_out_en_q;

  logic [7:0] offset;
  logic       in_win;
  logic       wr_cmd, wr_ctrl, rd_en;
  logic       fire_req, fire_entry, busy;
  logic [7:0] rd_data;
  logic       unused_data_bits;

  assign offset           = BUS_ADDR - BASE_ADDR;
  assign in_win           = (offset < 8'd4);
  assign unused_data_bits = ^BUS_DATA_IN[7:4];

  always_comb begin
    wr_cmd  = in_win && BUS_WE && (offset[1:0] == 2'd0);
    wr_ctrl = in_win && BUS_WE && (offset[1:0] == 2'd1);
    rd_en   = in_win && !BUS_WE;
    busy    = (state_q != StIdle);
  end

  always_comb begin
    fire_req   = pending_q || (enable_q && (pcnt_q == PeriodLast));
    fire_entry = 1'b0;
    state_d    = state_q;
    case (state_q)
      StIdle: begin
        if (fire_req) begin
          state_d    = StFire;
          fire_entry = 1'b1;
        end
      end
      StFire: state_d = StHold;
      StHold: begin
        if (hcnt_q == HoldLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (offset[1:0])
      2'd0:    rd_data = {4'b0000, cmd_stage_q};
      2'd1:    rd_data = {7'b0000000, enable_q};
      2'd2:    rd_data = {busy, pending_q, enable_q, 1'b0, command_q};
      default: rd_data = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= StIdle;
      cmd_stage_q   <= 4'h0;
      command_q     <= 4'h0;
      enable_q      <= 1'b0;
      pending_q     <= 1'b0;
      pkt_cnt_q     <= 8'h00;
      pcnt_q        <= '0;
      hcnt_q        <= '0;
      data_out_q    <= 8'h00;
      data_out_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_cmd)  cmd_stage_q <= BUS_DATA_IN[3:0];
      if (wr_ctrl) enable_q    <= BUS_DATA_IN[0];

      // A one-shot landing on the fire edge is kept so no request is lost.
      if (wr_ctrl && BUS_DATA_IN[1]) pending_q <= 1'b1;
      else if (fire_entry)           pending_q <= 1'b0;

      if (fire_entry) begin
        command_q <= cmd_stage_q;
        pkt_cnt_q <= pkt_cnt_q + 8'd1;
      end

      if (!enable_q || fire_entry)  pcnt_q <= '0;
      else if (pcnt_q != PeriodLast) pcnt_q <= pcnt_q + 1'b1;

      if (fire_entry)        hcnt_q <= '0;
      else if (busy)         hcnt_q <= hcnt_q + 1'b1;

      data_out_en_q <= rd_en;
      if (rd_en) data_out_q <= rd_data;
    end
  end

  assign COMMAND         = command_q;
  assign SEND_PACKET     = (state_q == StFire);
  assign BUS_DATA_OUT    = data_out_q;
  assign BUS_DATA_OUT_EN = data_out_en_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Directed bench for ir_packet_scheduler with PERIOD=100, HOLDOFF=40.
module tb_ir_packet_scheduler;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic [7:0] BUS_ADDR = 8'h00;
  logic [7:0] BUS_DATA_IN = 8'h00;
  logic       BUS_WE = 1'b0;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OUT_EN;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;

  ir_packet_scheduler #(
    .BASE_ADDR (8'h90),
    .PERIOD    (100),
    .HOLDOFF   (40),
    .CNT_W     (24)
  ) dut (
    .CLK             (CLK),
    .RESETN          (RESETN),
    .BUS_ADDR        (BUS_ADDR),
    .BUS_DATA_IN     (BUS_DATA_IN),
    .BUS_WE          (BUS_WE),
    .BUS_DATA_OUT    (BUS_DATA_OUT),
    .BUS_DATA_OUT_EN (BUS_DATA_OUT_EN),
    .COMMAND         (COMMAND),
    .SEND_PACKET     (SEND_PACKET)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Each entry is the cycle (posedge count) of a cycle in which SEND_PACKET was high.
  int         pulse_q[$];
  logic [3:0] pcmd_q[$];
  always @(negedge CLK) begin
    if (SEND_PACKET === 1'b1) begin
      pulse_q.push_back(cyc);
      pcmd_q.push_back(COMMAND);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output int wc);
    @(negedge CLK);
    BUS_ADDR = a; BUS_DATA_IN = d; BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_ADDR = 8'h00; BUS_DATA_IN = 8'h00; BUS_WE = 1'b0;
    wc = cyc;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic en);
    @(negedge CLK);
    BUS_ADDR = a; BUS_WE = 1'b0;
    @(negedge CLK);
    d = BUS_DATA_OUT; en = BUS_DATA_OUT_EN;
    BUS_ADDR = 8'h00;
  endtask

  task automatic wait_pulses(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && pulse_q.size() < n; i++) begin
      @(negedge CLK);
      #1;
    end
    ok = (pulse_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       en;
    #2 RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_read(8'(8'h90 + i), d, en);
      n_checks++;
      if ({en, d} !== 9'h100) $display("FAIL reset_read[%0d]: got en=%b data=%h want en=1 data=00", i, en, d);
      else n_pass++;
    end
    @(negedge CLK);
    n_checks++;
    if (BUS_DATA_OUT_EN !== 1'b0) $display("FAIL reset_out_en_idle: got %b want 0", BUS_DATA_OUT_EN);
    else n_pass++;
    n_checks++;
    if (COMMAND !== 4'h0) $display("FAIL reset_command: got %h want 0", COMMAND);
    else n_pass++;
    pulse_q.delete(); pcmd_q.delete();
    repeat (500) @(negedge CLK);
    n_checks++;
    if (pulse_q.size() != 0) $display("FAIL reset_no_pulse: got %0d pulses want 0", pulse_q.size());
    else n_pass++;
  endtask

  task automatic test_oneshot();
    int wc;
    logic [7:0] d;
    logic en;
    pulse_q.delete(); pcmd_q.delete();
    bus_write(8'h90, 8'h05, wc);
    bus_write(8'h91, 8'h02, wc);
    repeat (5) @(negedge CLK);
    bus_read(8'h92, d, en);
    n_checks++;
    if (d !== 8'h85) $display("FAIL oneshot_status_busy: got %h want 85", d);
    else n_pass++;
    repeat (50) @(negedge CLK);
    bus_read(8'h92, d, en);
    n_checks++;
    if (d !== 8'h05) $display("FAIL oneshot_status_idle: got %h want 05", d);
    else n_pass++;
    bus_read(8'h93, d, en);
    n_checks++;
    if (d !== 8'h01) $display("FAIL oneshot_pkt_cnt: got %h want 01", d);
    else n_pass++;
    n_checks++;
    if (pulse_q.size() != 1) $display("FAIL oneshot_pulse_count: got %0d want 1", pulse_q.size());
    else n_pass++;
    if (pulse_q.size() >= 1) begin
      n_checks++;
      if (pulse_q[0] != wc + 1) $display("FAIL oneshot_latency: got cycle %0d want %0d", pulse_q[0], wc + 1);
      else n_pass++;
      n_checks++;
      if (pcmd_q[0] !== 4'h5) $display("FAIL oneshot_command: got %h want 5", pcmd_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_periodic();
    int wc, dummy;
    bit ok;
    pulse_q.delete(); pcmd_q.delete();
    bus_write(8'h91, 8'h01, wc);
    wait_pulses(1, 150, ok);
    bus_write(8'h90, 8'h0A, dummy);
    n_checks++;
    if (COMMAND !== 4'h5) $display("FAIL periodic_cmd_frozen: got %h want 5", COMMAND);
    else n_pass++;
    wait_pulses(3, 250, ok);
    bus_write(8'h91, 8'h00, dummy);
    n_checks++;
    if (!ok) $display("FAIL periodic_timeout: got %0d pulses want 3", pulse_q.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < pulse_q.size(); i++) begin
      n_checks++;
      if (pulse_q[i] != wc + 100 * (i + 1))
        $display("FAIL periodic_time[%0d]: got cycle %0d want %0d", i, pulse_q[i], wc + 100 * (i + 1));
      else n_pass++;
      n_checks++;
      if (pcmd_q[i] !== ((i == 0) ? 4'h5 : 4'hA))
        $display("FAIL periodic_cmd[%0d]: got %h want %h", i, pcmd_q[i], (i == 0) ? 4'h5 : 4'hA);
      else n_pass++;
    end
    repeat (150) @(negedge CLK);
    n_checks++;
    if (pulse_q.size() != 3) $display("FAIL periodic_stop: got %0d pulses want 3", pulse_q.size());
    else n_pass++;
  endtask

  task automatic test_holdoff_pend();
    int w1, w2;
    bit ok;
    logic [7:0] d;
    logic en;
    pulse_q.delete(); pcmd_q.delete();
    bus_write(8'h91, 8'h02, w1);
    repeat (8) @(negedge CLK);
    bus_write(8'h91, 8'h02, w2);
    bus_read(8'h92, d, en);
    n_checks++;
    if (d !== 8'hCA) $display("FAIL pend_status: got %h want CA", d);
    else n_pass++;
    wait_pulses(2, 100, ok);
    n_checks++;
    if (!ok) $display("FAIL pend_timeout: got %0d pulses want 2", pulse_q.size());
    else n_pass++;
    if (ok) begin
      n_checks++;
      if (pulse_q[0] != w1 + 1) $display("FAIL pend_first: got cycle %0d want %0d", pulse_q[0], w1 + 1);
      else n_pass++;
      n_checks++;
      if (pulse_q[1] - pulse_q[0] != 40)
        $display("FAIL pend_spacing: got %0d want 40", pulse_q[1] - pulse_q[0]);
      else n_pass++;
    end
    repeat (60) @(negedge CLK);
    bus_read(8'h92, d, en);
    n_checks++;
    if (d !== 8'h0A) $display("FAIL pend_cleared: got %h want 0A", d);
    else n_pass++;
  endtask

  task automatic test_collision_wrap();
    int w, wc, dummy;
    bit ok;
    logic [7:0] d;
    logic en;
    pulse_q.delete(); pcmd_q.delete();
    bus_write(8'h91, 8'h01, w);
    while (cyc < w + 97) @(negedge CLK);
    bus_write(8'h91, 8'h03, wc);
    wait_pulses(1, 20, ok);
    bus_write(8'h91, 8'h00, dummy);
    repeat (150) @(negedge CLK);
    n_checks++;
    if (pulse_q.size() != 1) $display("FAIL collide_count: got %0d pulses want 1", pulse_q.size());
    else n_pass++;
    if (pulse_q.size() >= 1) begin
      n_checks++;
      if (pulse_q[0] != w + 100) $display("FAIL collide_time: got cycle %0d want %0d", pulse_q[0], w + 100);
      else n_pass++;
    end
    bus_read(8'h93, d, en);
    n_checks++;
    if (d !== 8'h07) $display("FAIL collide_pkt_cnt: got %h want 07", d);
    else n_pass++;
    for (int i = 0; i < 249; i++) begin
      bus_write(8'h91, 8'h02, dummy);
      repeat (42) @(negedge CLK);
    end
    bus_read(8'h93, d, en);
    n_checks++;
    if (d !== 8'h00) $display("FAIL wrap_zero: got %h want 00", d);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      bus_write(8'h91, 8'h02, dummy);
      repeat (42) @(negedge CLK);
    end
    bus_read(8'h93, d, en);
    n_checks++;
    if (d !== 8'h07) $display("FAIL wrap_after: got %h want 07", d);
    else n_pass++;
    n_checks++;
    if (pulse_q.size() != 257) $display("FAIL wrap_pulses: got %0d want 257", pulse_q.size());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int wc;
    logic [7:0] d;
    logic en;
    bus_write(8'h91, 8'h02, wc);
    @(negedge CLK);
    n_checks++;
    if (SEND_PACKET !== 1'b1) $display("FAIL ares_fire_seen: got %b want 1", SEND_PACKET);
    else n_pass++;
    #1 RESETN = 1'b0;
    #1;
    n_checks++;
    if (SEND_PACKET !== 1'b0) $display("FAIL ares_pulse_drop: got %b want 0", SEND_PACKET);
    else n_pass++;
    @(negedge CLK);
    RESETN = 1'b1;
    bus_write(8'h90, 8'h03, wc);
    bus_write(8'h91, 8'h02, wc);
    repeat (6) @(negedge CLK);
    n_checks++;
    if (COMMAND !== 4'h3) $display("FAIL ares_cmd_before: got %h want 3", COMMAND);
    else n_pass++;
    #2 RESETN = 1'b0;
    #1;
    n_checks++;
    if (COMMAND !== 4'h0) $display("FAIL ares_cmd_cleared: got %h want 0", COMMAND);
    else n_pass++;
    @(negedge CLK);
    RESETN = 1'b1;
    pulse_q.delete(); pcmd_q.delete();
    bus_read(8'h92, d, en);
    n_checks++;
    if (d !== 8'h00) $display("FAIL ares_status: got %h want 00", d);
    else n_pass++;
    repeat (300) @(negedge CLK);
    n_checks++;
    if (pulse_q.size() != 0) $display("FAIL ares_no_pulse: got %0d pulses want 0", pulse_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_holdoff_pend();
    test_collision_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
